// File: rtl/alu_reg_pipeline.sv
// Three-stage integer ALU pipeline (operand collect, execute, writeback) placed
// downstream of the ALU issue queue, with a valid/ready handshake to the writeback arbiter.
module alu_reg_pipeline #(
    parameter  int LOG_PR_COUNT       = 7,
    parameter  int PRF_BANK_COUNT     = 4,
    parameter  int LOG_ROB_ENTRIES    = 7,
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT)
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 issue_valid,
    input  logic [3:0]                           issue_op,
    input  logic                                 issue_is_imm,
    input  logic [31:0]                          issue_imm,
    input  logic                                 issue_A_unneeded,
    input  logic                                 issue_A_forward,
    input  logic                                 issue_B_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank,
    input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_B_bank,
    input  logic [LOG_PR_COUNT-1:0]              issue_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]           issue_ROB_index,
    output logic                                 pipeline_ready,
    input  logic                                 A_reg_read_ack,
    input  logic                                 B_reg_read_ack,
    input  logic [31:0]                          A_reg_read_data,
    input  logic [31:0]                          B_reg_read_data,
    input  logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank,
    output logic                                 WB_valid,
    output logic [31:0]                          WB_data,
    output logic [LOG_PR_COUNT-1:0]              WB_PR,
    output logic [LOG_ROB_ENTRIES-1:0]           WB_ROB_index,
    input  logic                                 WB_ready
);

    // ALU datapath: the immediate form of opcode 1000 is ADDI, so it adds instead of subtracting
    function automatic logic [31:0] alu_compute(
        input logic [3:0]  op,
        input logic        is_imm,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0]  sh;
        logic [31:0] res;
        sh = b[4:0];
        case (op)
            4'b0000: res = a + b;
            4'b1000: res = is_imm ? (a + b) : (a - b);
            4'b0001: res = a << sh;
            4'b0010: res = {31'd0, ($signed(a) < $signed(b))};
            4'b0011: res = {31'd0, (a < b)};
            4'b0100: res = a ^ b;
            4'b0101: res = a >> sh;
            4'b1101: res = $signed(a) >>> sh;
            4'b0110: res = a | b;
            4'b0111: res = a & b;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // OC stage state
    logic                          r_oc_valid;
    logic                          r_oc_first;
    logic [3:0]                    r_oc_op;
    logic                          r_oc_is_imm;
    logic                          r_oc_a_fwd;
    logic                          r_oc_b_fwd;
    logic [LOG_PRF_BANK_COUNT-1:0] r_oc_a_bank;
    logic [LOG_PRF_BANK_COUNT-1:0] r_oc_b_bank;
    logic                          r_oc_a_done;
    logic                          r_oc_b_done;
    logic [31:0]                   r_oc_a_val;
    logic [31:0]                   r_oc_b_val;
    logic [LOG_PR_COUNT-1:0]       r_oc_pr;
    logic [LOG_ROB_ENTRIES-1:0]    r_oc_rob;

    // EX stage state
    logic                          r_ex_valid;
    logic [3:0]                    r_ex_op;
    logic                          r_ex_is_imm;
    logic [31:0]                   r_ex_a;
    logic [31:0]                   r_ex_b;
    logic [LOG_PR_COUNT-1:0]       r_ex_pr;
    logic [LOG_ROB_ENTRIES-1:0]    r_ex_rob;

    // WB stage state
    logic                          r_wb_valid;
    logic [31:0]                   r_wb_data;
    logic [LOG_PR_COUNT-1:0]       r_wb_pr;
    logic [LOG_ROB_ENTRIES-1:0]    r_wb_rob;

    logic        w_a_fwd_now;
    logic        w_b_fwd_now;
    logic        w_a_ack_now;
    logic        w_b_ack_now;
    logic        w_a_done;
    logic        w_b_done;
    logic [31:0] w_a_eff;
    logic [31:0] w_b_eff;
    logic        w_ex_adv;
    logic        w_oc_adv;
    logic        w_issue_acc;

    // Forward data exists only in the first OC cycle; acks count only for non-forward operands
    assign w_a_fwd_now = r_oc_first & r_oc_a_fwd;
    assign w_b_fwd_now = r_oc_first & r_oc_b_fwd;
    assign w_a_ack_now = ~r_oc_a_fwd & A_reg_read_ack;
    assign w_b_ack_now = ~r_oc_b_fwd & B_reg_read_ack;

    assign w_a_done = r_oc_a_done | w_a_fwd_now | w_a_ack_now;
    assign w_b_done = r_oc_b_done | w_b_fwd_now | w_b_ack_now;

    assign w_a_eff = r_oc_a_done ? r_oc_a_val :
                     (w_a_fwd_now ? forward_data_by_bank[r_oc_a_bank] : A_reg_read_data);
    assign w_b_eff = r_oc_b_done ? r_oc_b_val :
                     (w_b_fwd_now ? forward_data_by_bank[r_oc_b_bank] : B_reg_read_data);

    // Ready chain runs combinationally from WB back to the issue queue
    assign w_ex_adv       = r_ex_valid & (~r_wb_valid | WB_ready);
    assign w_oc_adv       = r_oc_valid & w_a_done & w_b_done & (~r_ex_valid | w_ex_adv);
    assign pipeline_ready = ~r_oc_valid | w_oc_adv;
    assign w_issue_acc    = issue_valid & pipeline_ready;

    // OC stage: load a newly issued op or collect outstanding operands
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_oc_valid  <= 1'b0;
            r_oc_first  <= 1'b0;
            r_oc_op     <= 4'd0;
            r_oc_is_imm <= 1'b0;
            r_oc_a_fwd  <= 1'b0;
            r_oc_b_fwd  <= 1'b0;
            r_oc_a_bank <= '0;
            r_oc_b_bank <= '0;
            r_oc_a_done <= 1'b0;
            r_oc_b_done <= 1'b0;
            r_oc_a_val  <= 32'd0;
            r_oc_b_val  <= 32'd0;
            r_oc_pr     <= '0;
            r_oc_rob    <= '0;
        end else if (w_issue_acc) begin
            r_oc_valid  <= 1'b1;
            r_oc_first  <= 1'b1;
            r_oc_op     <= issue_op;
            r_oc_is_imm <= issue_is_imm;
            r_oc_a_fwd  <= issue_A_forward;
            r_oc_b_fwd  <= issue_B_forward;
            r_oc_a_bank <= issue_A_bank;
            r_oc_b_bank <= issue_B_bank;
            r_oc_a_done <= issue_A_unneeded;
            r_oc_b_done <= issue_is_imm;
            r_oc_a_val  <= 32'd0;
            r_oc_b_val  <= issue_is_imm ? issue_imm : 32'd0;
            r_oc_pr     <= issue_dest_PR;
            r_oc_rob    <= issue_ROB_index;
        end else begin
            r_oc_first <= 1'b0;
            if (w_oc_adv) begin
                r_oc_valid <= 1'b0;
            end else begin
                r_oc_valid <= r_oc_valid;
            end
            // A stalled op keeps whatever arrived this cycle, including first-cycle forward data
            if (r_oc_valid & ~r_oc_a_done & w_a_done) begin
                r_oc_a_val  <= w_a_eff;
                r_oc_a_done <= 1'b1;
            end else begin
                r_oc_a_val  <= r_oc_a_val;
                r_oc_a_done <= r_oc_a_done;
            end
            if (r_oc_valid & ~r_oc_b_done & w_b_done) begin
                r_oc_b_val  <= w_b_eff;
                r_oc_b_done <= 1'b1;
            end else begin
                r_oc_b_val  <= r_oc_b_val;
                r_oc_b_done <= r_oc_b_done;
            end
        end
    end

    // EX stage: latch the collected operands when OC hands an op forward
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex_valid  <= 1'b0;
            r_ex_op     <= 4'd0;
            r_ex_is_imm <= 1'b0;
            r_ex_a      <= 32'd0;
            r_ex_b      <= 32'd0;
            r_ex_pr     <= '0;
            r_ex_rob    <= '0;
        end else if (w_oc_adv) begin
            r_ex_valid  <= 1'b1;
            r_ex_op     <= r_oc_op;
            r_ex_is_imm <= r_oc_is_imm;
            r_ex_a      <= w_a_eff;
            r_ex_b      <= w_b_eff;
            r_ex_pr     <= r_oc_pr;
            r_ex_rob    <= r_oc_rob;
        end else if (w_ex_adv) begin
            r_ex_valid  <= 1'b0;
        end else begin
            r_ex_valid  <= r_ex_valid;
        end
    end

    // WB stage: capture the ALU result and hold it until the arbiter takes it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_pr    <= '0;
            r_wb_rob   <= '0;
        end else if (w_ex_adv) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= alu_compute(r_ex_op, r_ex_is_imm, r_ex_a, r_ex_b);
            r_wb_pr    <= r_ex_pr;
            r_wb_rob   <= r_ex_rob;
        end else if (WB_ready) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end

    assign WB_valid     = r_wb_valid;
    assign WB_data      = r_wb_data;
    assign WB_PR        = r_wb_pr;
    assign WB_ROB_index = r_wb_rob;

endmodule

// File: tb/tb_alu_reg_pipeline.sv
// Scoreboard bench for alu_reg_pipeline: directed scenarios plus randomized ops,
// expected results from an arithmetic reference model, checked by an independent monitor.
module tb_alu_reg_pipeline;
    localparam int LPR  = 7;
    localparam int NB   = 4;
    localparam int LB   = 2;
    localparam int LROB = 7;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RST = 1'b1;
    logic                 issue_valid = 1'b0;
    logic [3:0]           issue_op = 4'd0;
    logic                 issue_is_imm = 1'b0;
    logic [31:0]          issue_imm = 32'd0;
    logic                 issue_A_unneeded = 1'b0;
    logic                 issue_A_forward = 1'b0;
    logic                 issue_B_forward = 1'b0;
    logic [LB-1:0]        issue_A_bank = '0;
    logic [LB-1:0]        issue_B_bank = '0;
    logic [LPR-1:0]       issue_dest_PR = '0;
    logic [LROB-1:0]      issue_ROB_index = '0;
    logic                 pipeline_ready;
    logic                 A_reg_read_ack = 1'b0;
    logic                 B_reg_read_ack = 1'b0;
    logic [31:0]          A_reg_read_data = 32'd0;
    logic [31:0]          B_reg_read_data = 32'd0;
    logic [NB-1:0][31:0]  forward_data_by_bank = '0;
    logic                 WB_valid;
    logic [31:0]          WB_data;
    logic [LPR-1:0]       WB_PR;
    logic [LROB-1:0]      WB_ROB_index;
    logic                 WB_ready = 1'b1;

    alu_reg_pipeline #(.LOG_PR_COUNT(LPR), .PRF_BANK_COUNT(NB), .LOG_ROB_ENTRIES(LROB)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_is_imm(issue_is_imm),
        .issue_imm(issue_imm), .issue_A_unneeded(issue_A_unneeded),
        .issue_A_forward(issue_A_forward), .issue_B_forward(issue_B_forward),
        .issue_A_bank(issue_A_bank), .issue_B_bank(issue_B_bank),
        .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index),
        .pipeline_ready(pipeline_ready),
        .A_reg_read_ack(A_reg_read_ack), .B_reg_read_ack(B_reg_read_ack),
        .A_reg_read_data(A_reg_read_data), .B_reg_read_data(B_reg_read_data),
        .forward_data_by_bank(forward_data_by_bank),
        .WB_valid(WB_valid), .WB_data(WB_data), .WB_PR(WB_PR),
        .WB_ROB_index(WB_ROB_index), .WB_ready(WB_ready)
    );

    typedef struct {
        logic [3:0]      op;
        logic            is_imm;
        logic [31:0]     imm;
        logic            a_un;
        logic            a_fwd;
        logic            b_fwd;
        logic [LB-1:0]   a_bank;
        logic [LB-1:0]   b_bank;
        logic [31:0]     a_val;
        logic [31:0]     b_val;
        int              a_dly;
        int              b_dly;
        logic [LPR-1:0]  pr;
        logic [LROB-1:0] rob;
        logic [31:0]     exp;
    } op_t;

    typedef struct packed {
        logic [31:0]     d;
        logic [LPR-1:0]  pr;
        logic [LROB-1:0] rob;
    } exp_t;

    op_t  pend[$];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    op_t  cur;
    op_t  nxt;
    int   cur_age = -1;
    bit   cur_a_acked = 1'b0;
    bit   cur_b_acked = 1'b0;
    bit   have_nxt = 1'b0;
    int   issue_pct = 100;
    int   wbr_pct = 100;
    int   wbr_low = 0;
    bit   seen_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: result straight from the instruction-set meaning of each opcode
    function automatic logic [31:0] ref_result(input op_t o);
        logic [31:0] a;
        logic [31:0] b;
        int          sh;
        a  = o.a_un ? 32'd0 : o.a_val;
        b  = o.is_imm ? o.imm : o.b_val;
        sh = int'(b % 32);
        case (o.op)
            4'd0:    return a + b;
            4'd8:    return o.is_imm ? a + b : a - b;
            4'd1:    return a << sh;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd13:   return 32'($signed(a) >>> sh);
            4'd6:    return a | b;
            4'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic op_t mk(input logic [3:0] op, input logic is_imm, input logic [31:0] imm,
                               input logic a_fwd, input logic [LB-1:0] a_bank,
                               input logic [31:0] a_val, input int a_dly,
                               input logic b_fwd, input logic [LB-1:0] b_bank,
                               input logic [31:0] b_val, input int b_dly,
                               input logic [LPR-1:0] pr, input logic [LROB-1:0] rob,
                               input logic [31:0] exp);
        op_t o;
        o.op = op; o.is_imm = is_imm; o.imm = imm; o.a_un = 1'b0;
        o.a_fwd = a_fwd; o.a_bank = a_bank; o.a_val = a_val; o.a_dly = a_dly;
        o.b_fwd = b_fwd; o.b_bank = b_bank; o.b_val = b_val; o.b_dly = b_dly;
        o.pr = pr; o.rob = rob; o.exp = exp;
        return o;
    endfunction

    function automatic op_t gen_random();
        op_t o;
        o.op     = 4'($urandom_range(15));
        o.is_imm = ($urandom_range(99) < 40);
        o.imm    = $urandom;
        o.a_un   = ($urandom_range(99) < 15);
        o.a_fwd  = !o.a_un && ($urandom_range(99) < 30);
        o.b_fwd  = !o.is_imm && ($urandom_range(99) < 30);
        o.a_bank = LB'($urandom_range(NB - 1));
        o.b_bank = LB'($urandom_range(NB - 1));
        o.a_val  = ($urandom_range(3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
        o.b_val  = $urandom;
        if (o.a_fwd && o.b_fwd && o.a_bank == o.b_bank) o.b_val = o.a_val;
        o.a_dly  = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
        o.b_dly  = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
        o.pr     = LPR'($urandom);
        o.rob    = LROB'($urandom);
        o.exp    = ref_result(o);
        return o;
    endfunction

    // One clock of stimulus: PRF/forward responses for the op in OC, WB_ready, next issue
    task automatic cycle();
        bit spur;
        @(negedge CLK);
        if (have_nxt) begin
            cur = nxt; cur_age = 0; cur_a_acked = 1'b0; cur_b_acked = 1'b0; have_nxt = 1'b0;
        end else if (cur_age >= 0) begin
            cur_age++;
        end
        for (int i = 0; i < NB; i++) forward_data_by_bank[i] = $urandom;
        A_reg_read_ack = 1'b0; A_reg_read_data = $urandom;
        B_reg_read_ack = 1'b0; B_reg_read_data = $urandom;
        if (cur_age >= 0) begin
            if (cur_age == 0 && cur.a_fwd && !cur.a_un) forward_data_by_bank[cur.a_bank] = cur.a_val;
            if (cur_age == 0 && cur.b_fwd && !cur.is_imm) forward_data_by_bank[cur.b_bank] = cur.b_val;
            spur = ($urandom_range(99) < 30);
            if (!cur.a_un && !cur.a_fwd && !cur_a_acked) begin
                if (cur_age >= cur.a_dly) begin
                    A_reg_read_ack = 1'b1; A_reg_read_data = cur.a_val; cur_a_acked = 1'b1;
                end
            end else if (cur.a_un || !cur.a_fwd || cur_age > 0) begin
                A_reg_read_ack = spur;
            end
            spur = ($urandom_range(99) < 30);
            if (!cur.is_imm && !cur.b_fwd && !cur_b_acked) begin
                if (cur_age >= cur.b_dly) begin
                    B_reg_read_ack = 1'b1; B_reg_read_data = cur.b_val; cur_b_acked = 1'b1;
                end
            end else if (cur.is_imm || !cur.b_fwd || cur_age > 0) begin
                B_reg_read_ack = spur;
            end
        end else begin
            A_reg_read_ack = ($urandom_range(99) < 30);
            B_reg_read_ack = ($urandom_range(99) < 30);
        end
        if (wbr_low > 0) begin
            WB_ready = 1'b0; wbr_low--;
        end else begin
            WB_ready = (int'($urandom_range(99)) < wbr_pct);
        end
        issue_op = 4'($urandom); issue_is_imm = 1'($urandom); issue_imm = $urandom;
        issue_A_unneeded = 1'($urandom); issue_A_forward = 1'($urandom);
        issue_B_forward = 1'($urandom); issue_A_bank = LB'($urandom);
        issue_B_bank = LB'($urandom); issue_dest_PR = LPR'($urandom);
        issue_ROB_index = LROB'($urandom);
        issue_valid = 1'b0;
        if (pend.size() > 0 && int'($urandom_range(99)) < issue_pct) begin
            issue_valid = 1'b1;
            issue_op = pend[0].op; issue_is_imm = pend[0].is_imm; issue_imm = pend[0].imm;
            issue_A_unneeded = pend[0].a_un; issue_A_forward = pend[0].a_fwd;
            issue_B_forward = pend[0].b_fwd; issue_A_bank = pend[0].a_bank;
            issue_B_bank = pend[0].b_bank; issue_dest_PR = pend[0].pr;
            issue_ROB_index = pend[0].rob;
        end
        #1;
        seen_ready = pipeline_ready;
        if (issue_valid && pipeline_ready) begin
            nxt = pend.pop_front();
            have_nxt = 1'b1;
            sbq.push_back('{d: nxt.exp, pr: nxt.pr, rob: nxt.rob});
        end
        @(posedge CLK);
    endtask

    task automatic wait_accept(input string name);
        int g;
        g = 0;
        do begin cycle(); g++; end while (!have_nxt && g < 20);
        chk(name, 64'(have_nxt), 64'd1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((pend.size() > 0 || sbq.size() > 0) && n < bound) begin
            cycle(); n++;
        end
        chk("drain_outstanding", 64'(pend.size() + sbq.size()), 64'd0);
    endtask

    // Monitor: compares every WB transfer with the scoreboard and checks held WB stays stable
    bit   mon_hold = 1'b0;
    exp_t mon_prev;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) begin
                    chk("wb_hold_valid", 64'(WB_valid), 64'd1);
                    chk("wb_hold_stable", 64'({WB_data, WB_PR, WB_ROB_index}), 64'(mon_prev));
                end
                if (WB_valid && WB_ready) begin
                    if (sbq.size() == 0) begin
                        chk("wb_unexpected_valid", 64'(WB_valid), 64'd0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("wb_data", 64'(WB_data), 64'(mon_e.d));
                        chk("wb_pr", 64'(WB_PR), 64'(mon_e.pr));
                        chk("wb_rob", 64'(WB_ROB_index), 64'(mon_e.rob));
                    end
                end
                mon_hold = WB_valid && !WB_ready;
                mon_prev = {WB_data, WB_PR, WB_ROB_index};
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        issue_valid = 1'b1;
        A_reg_read_ack = 1'b1; A_reg_read_data = 32'hDEAD_BEEF;
        B_reg_read_ack = 1'b1; B_reg_read_data = 32'hCAFE_F00D;
        @(posedge CLK);
        pend.delete(); sbq.delete();
        have_nxt = 1'b0; cur_age = -1;
        @(negedge CLK);
        RST = 1'b0; issue_valid = 1'b0; A_reg_read_ack = 1'b0; B_reg_read_ack = 1'b0;
        #1;
        chk("rst_wb_valid", 64'(WB_valid), 64'd0);
        chk("rst_ready", 64'(pipeline_ready), 64'd1);
    endtask

    int lows;

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_wb_valid", 64'(WB_valid), 64'd0);
        chk("reset_wb_data", 64'(WB_data), 64'd0);
        chk("reset_wb_pr", 64'(WB_PR), 64'd0);
        chk("reset_wb_rob", 64'(WB_ROB_index), 64'd0);
        chk("reset_ready", 64'(pipeline_ready), 64'd1);

        // ADDI 5 + 7, best-case latency
        pend.push_back(mk(4'b0000, 1'b1, 32'd7, 1'b0, 2'd0, 32'd5, 0,
                          1'b0, 2'd0, 32'd0, 0, 7'd3, 7'd9, 32'd12));
        wait_accept("addi_accept");
        cycle(); #1;
        chk("lat_wb_not_yet", 64'(WB_valid), 64'd0);
        cycle(); #1;
        chk("lat_wb_valid", 64'(WB_valid), 64'd1);
        drain(50);

        // SUB with forwarded A and PRF B
        pend.push_back(mk(4'b1000, 1'b0, 32'd0, 1'b1, 2'd2, 32'h10, 0,
                          1'b0, 2'd0, 32'h11, 0, 7'd4, 7'd10, 32'hFFFF_FFFF));
        drain(50);

        // B ack three cycles late; forwarded A must be retained across the stall
        pend.push_back(mk(4'b0000, 1'b0, 32'd0, 1'b1, 2'd1, 32'h100, 0,
                          1'b0, 2'd0, 32'h23, 3, 7'd5, 7'd11, 32'h123));
        wait_accept("late_accept");
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("late_ready", 64'(seen_ready), (k == 3) ? 64'd1 : 64'd0);
        end
        drain(50);

        // Four back-to-back ops into a held WB
        wbr_low = 8;
        for (int k = 0; k < 4; k++)
            pend.push_back(mk(4'b0000, 1'b1, 32'(k * 16), 1'b0, 2'd0, 32'd1, 0,
                              1'b0, 2'd0, 32'd0, 0, 7'(20 + k), 7'(40 + k), 32'(k * 16 + 1)));
        lows = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (!seen_ready) lows++;
        end
        chk("b2b_ready_dropped", 64'(lows > 0), 64'd1);
        drain(50);

        // Shift and compare corners
        pend.push_back(mk(4'b1101, 1'b0, 32'd0, 1'b0, 2'd0, 32'h8000_0000, 0,
                          1'b0, 2'd0, 32'h24, 0, 7'd6, 7'd12, 32'hF800_0000));
        pend.push_back(mk(4'b0010, 1'b0, 32'd0, 1'b0, 2'd0, 32'hFFFF_FFFF, 1,
                          1'b0, 2'd0, 32'd1, 0, 7'd7, 7'd13, 32'd1));
        pend.push_back(mk(4'b0011, 1'b0, 32'd0, 1'b0, 2'd0, 32'hFFFF_FFFF, 0,
                          1'b0, 2'd0, 32'd1, 2, 7'd8, 7'd14, 32'd0));
        drain(80);

        // Reset with ops in flight, then a clean op
        wbr_low = 20;
        for (int k = 0; k < 3; k++) pend.push_back(gen_random());
        repeat (5) cycle();
        do_reset();
        wbr_low = 0;
        pend.push_back(mk(4'b0110, 1'b0, 32'd0, 1'b0, 2'd0, 32'hF0F0_0000, 0,
                          1'b0, 2'd0, 32'h0000_0F0F, 0, 7'd1, 7'd2, 32'hF0F0_0F0F));
        drain(50);

        // Randomized traffic with backpressure
        issue_pct = 80;
        wbr_pct = 70;
        for (int k = 0; k < 400; k++) pend.push_back(gen_random());
        drain(6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
